// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared widths, reset divisor, run-state and divisor types for pulse_rate_gen
package pulse_gen_pkg;
  localparam int DIV_W = 16;
  localparam int DEFAULT_DIV = 25;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  typedef logic [DIV_W-1:0] div_t;
endpackage

// File: rtl/pulse_rate_gen_load_down_counter.sv
// load_down_counter: down counter (clk rst en load load_val -> zero) that reloads on load and saturates at 0
module load_down_counter #(
  parameter int W = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/pulse_rate_gen.sv
// pulse_rate_gen: run-time reloadable strobe divider; in clk rst en div_in div_load (sync_in under PULSE_SYNC_EN), out pulse div_ack pending
module pulse_rate_gen #(
  parameter int DIV_W = pulse_gen_pkg::DIV_W,
  parameter int DEFAULT_DIV = pulse_gen_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
`ifdef PULSE_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             div_ack,
  output logic             pending,
  output logic             pulse
);
  import pulse_gen_pkg::*;
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
  logic [DIV_W-1:0] div_active, div_shadow, load_val;
  logic zero, term, apply, ld, sync_run;
  state_t st;
  always_comb begin
    st = !en ? IDLE : (div_active == '0 ? STOP : RUN);
`ifdef PULSE_SYNC_EN
    sync_run = sync_in && st == RUN;
`else
    sync_run = 1'b0;
`endif
    term = st == RUN && zero;
    apply = pending && (term || sync_run || st != RUN);
    ld = apply || (st == RUN && (zero || sync_run));
    load_val = apply ? (div_shadow == '0 ? '0 : div_shadow - ONE) : div_active - ONE;
  end
  load_down_counter #(.W(DIV_W), .RST_VAL(DEF - ONE)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en(st == RUN),
    .load(ld),
    .load_val(load_val),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      div_active <= DEF;
      div_shadow <= DEF;
      pending <= 1'b0;
      div_ack <= 1'b0;
      pulse <= 1'b0;
    end else begin
      if (div_load) div_shadow <= div_in;
      if (apply) div_active <= div_shadow;
      pending <= div_load || (pending && !apply);
      div_ack <= apply;
      pulse <= term && !sync_run;
    end
  end
endmodule

// File: tb/tb_pulse_rate_gen.sv
// tb_pulse_rate_gen: directed checks of spacing, reload, STOP, enable freeze, reset and optional sync
module tb_pulse_rate_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0, div_ack, pending, pulse;
  logic [15:0] div_in = '0;
`ifdef PULSE_SYNC_EN
  logic sync_in = 1'b0;
`endif
  int total = 0, bad = 0, n;
  always #5 clk = ~clk;
  pulse_rate_gen dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div_in(div_in),
    .div_load(div_load),
`ifdef PULSE_SYNC_EN
    .sync_in(sync_in),
`endif
    .div_ack(div_ack),
    .pending(pending),
    .pulse(pulse)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wait_pulse(input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (pulse) begin
        cnt = i;
        break;
      end
    end
  endtask
  task automatic load(input int v);
    div_in = 16'(v);
    div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask
  initial begin
    tick(2);
    check("rst_pulse", pulse, 0);
    check("rst_ack", div_ack, 0);
    check("rst_pending", pending, 0);
    rst = 1'b0;
    en = 1'b1;
    wait_pulse(60, n);
    check("first_pulse", n, 25);
    tick(1);
    check("pulse_width", pulse, 0);
    wait_pulse(60, n);
    check("gap25", n, 24);
    tick(14);
    load(4);
    check("mid_pending", pending, 1);
    check("mid_noack", div_ack, 0);
    wait_pulse(60, n);
    check("old_period_done", n, 10);
    check("ack4", div_ack, 1);
    check("pend_clr4", pending, 0);
    wait_pulse(60, n);
    check("gap4", n, 4);
    check("ack4_once", div_ack, 0);
    load(7);
    load(3);
    check("dbl_pending", pending, 1);
    wait_pulse(60, n);
    check("dbl_term", n, 2);
    check("dbl_ack", div_ack, 1);
    check("dbl_pend_clr", pending, 0);
    wait_pulse(60, n);
    check("gap3", n, 3);
    check("dbl_single_ack", div_ack, 0);
    load(1);
    wait_pulse(60, n);
    check("to_div1", n, 2);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("div1_high", pulse, 1);
    end
    load(0);
    check("div0_last_term", pulse, 1);
    tick(1);
    check("div0_ack", div_ack, 1);
    check("div0_apply_pulse", pulse, 1);
    tick(1);
    check("stop_low", pulse, 0);
    tick(3);
    check("stop_hold", pulse, 0);
    check("stop_pend", pending, 0);
    load(5);
    check("stop_load_pend", pending, 1);
    tick(1);
    check("stop_apply_ack", div_ack, 1);
    check("stop_apply_pulse", pulse, 0);
    wait_pulse(60, n);
    check("resume5", n, 5);
    load(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_pulse", pulse, 0);
    check("midrst_ack", div_ack, 0);
    check("midrst_pending", pending, 0);
    tick(12);
    en = 1'b0;
    tick(9);
    check("idle_nopulse", pulse, 0);
    en = 1'b1;
    wait_pulse(60, n);
    check("freeze_resume", n, 13);
    wait_pulse(60, n);
    check("rst_cleared_load", n, 25);
    en = 1'b0;
    load(2);
    check("idle_pending", pending, 1);
    tick(1);
    check("idle_apply_ack", div_ack, 1);
    check("idle_apply_pend", pending, 0);
    en = 1'b1;
    wait_pulse(60, n);
    check("idle_applied2", n, 2);
`ifdef PULSE_SYNC_EN
    load(10);
    wait_pulse(60, n);
    check("sync_setup", n, 1);
    tick(6);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    check("sync_nopulse", pulse, 0);
    wait_pulse(60, n);
    check("sync_realign", n, 10);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
